// File: rtl/rr_arbiter_fsm.sv
// N-requester arbiter for one shared resource: fixed-priority or round-robin winner
// select, direct holder-to-holder handoff, and optional preemption after MAX_HOLD cycles.
module rr_arbiter_fsm #(
    parameter  int N        = 4,
    parameter  int RR_MODE  = 1,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1,
    localparam int HCW      = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [HCW-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HCW-1:0] HOLD_SAT = '1;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [IDW-1:0] last_q, last_d;

    logic [N-1:0]   cand;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_onehot;
    logic [HCW-1:0] hold_inc;
    logic           preempt_due;
    logic           take;

    // The current holder is never a candidate; in IDLE gnt_q is zero so nothing is masked.
    assign cand = req & ~gnt_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (RR_MODE != 0) begin
            // Scan downwards so the nearest index after the pointer wins last.
            for (int k = N; k >= 1; k--) begin
                if (cand[(int'(last_q) + k) % N]) begin
                    win_found = 1'b1;
                    win_idx   = IDW'((int'(last_q) + k) % N);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(i);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_win_dec
            assign win_onehot[gi] = (win_idx == IDW'(gi));
        end
    endgenerate

    assign hold_inc = (hold_q == HOLD_SAT) ? hold_q : hold_q + HCW'(1);
    // >= rather than == so a waiter arriving after the counter passed MAX_HOLD still preempts.
    assign preempt_due = (MAX_HOLD != 0) && (int'(hold_q) >= MAX_HOLD);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        hold_d   = hold_q;
        last_d   = last_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) take = 1'b1;
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        hold_d   = '0;
                    end
                end else begin
                    hold_d = hold_inc;
                    if (preempt_due && win_found) take = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
        if (take) begin
            state_d  = GRANT;
            gnt_d    = win_onehot;
            gnt_id_d = win_idx;
            hold_d   = HCW'(1);
            last_d   = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            hold_q   <= '0;
            last_q   <= IDW'(N - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANT);
    assign gnt_id    = gnt_id_q;
    assign hold_cnt  = hold_q;

endmodule
